// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// data (load/store) stage. One access in flight at a time; data wins ties.
// Optional macro ARB_STARVE_EN: after STARVE_MAX consecutive data grants made
// while fetch was waiting, the next tie goes to fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_f,
    // data side
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_m,
    // memory side
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic              grant_if, grant_dm;
    logic              starved;

    // A zero threshold would hand every tie to fetch; reject it at elaboration.
    if (STARVE_MAX == 0) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

`ifdef ARB_STARVE_EN
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    logic [CntW-1:0] starve_q, starve_d;

    assign starved = (starve_q == CntW'(STARVE_MAX));

    // Count data grants taken while fetch was waiting; any other grant clears.
    always_comb begin
        starve_d = starve_q;
        if (grant_if) begin
            starve_d = '0;
        end else if (grant_dm) begin
            starve_d = if_req ? starve_q + CntW'(1) : '0;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    // Arbitration: only in idle; data first unless fetch has waited too long.
    always_comb begin
        grant_dm = (state_q == StIdle) && dm_req && !(if_req && starved);
        grant_if = (state_q == StIdle) && if_req && !grant_dm;
    end

    // Next-state, request latching and read-data capture
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_dm) begin
                    addr_d  = dm_addr;
                    we_d    = dm_we;
                    wdata_d = dm_wdata;
                    state_d = StBusyDm;
                end else if (grant_if) begin
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    state_d = StBusyIf;
                end
            end
            StBusyIf: begin
                if (ram_ack) begin
                    if_rdata_d = ram_rdata;
                    if_valid_d = 1'b1;
                    state_d    = StDone;
                end
            end
            StBusyDm: begin
                if (ram_ack) begin
                    // Stores leave the last load data in place.
                    if (!we_q) begin
                        dm_rdata_d = ram_rdata;
                    end
                    dm_valid_d = 1'b1;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
        end
    end

    // Memory-side and pipeline-side outputs
    always_comb begin
        ram_req   = (state_q == StBusyIf) || (state_q == StBusyDm);
        ram_we    = (state_q == StBusyDm) && we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        if_valid  = if_valid_q;
        dm_valid  = dm_valid_q;
        stall_f   = if_req & ~if_valid_q;
        stall_m   = dm_req & ~dm_valid_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random requesters and a random-latency memory.
// Expected behaviour comes from per-access timestamps (grant cycle, latency).
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_valid, stall_f;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_valid, stall_m;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          ram_req, ram_we, ram_ack;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    mem_port_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .stall_f  (stall_f),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .stall_m  (stall_m),
        .ram_req  (ram_req),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .ram_ack  (ram_ack)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference state: one outstanding access described by when it was granted.
    int            cyc;
    bit            active;
    int            t0, lat;
    bit            g_dm, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, ack_data;
    logic [DW-1:0] m_if_rdata, m_dm_rdata;
    int            streak;
    bit            quiet;
    int            n_if, n_dm;

    function automatic bit model_idle();
        return !active || (cyc >= t0 + 3 + lat);
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ram_req"}, ram_req, 0);
        check_eq({tag, "_ram_we"}, ram_we, 0);
        check_eq({tag, "_ram_addr"}, ram_addr, 0);
        check_eq({tag, "_ram_wdata"}, ram_wdata, 0);
        check_eq({tag, "_if_valid"}, if_valid, 0);
        check_eq({tag, "_dm_valid"}, dm_valid, 0);
        check_eq({tag, "_if_rdata"}, if_rdata, 0);
        check_eq({tag, "_dm_rdata"}, dm_rdata, 0);
    endtask

    // One cycle, entered at a falling edge: drive, check, then predict the grant.
    task automatic step();
        bit busy, vld, e_ifv, e_dmv, pick_if;
        busy  = active && (cyc >= t0 + 1) && (cyc <= t0 + 1 + lat);
        vld   = active && (cyc == t0 + 2 + lat);
        e_ifv = vld && !g_dm;
        e_dmv = vld && g_dm;
        if (vld) begin
            if (!g_dm) m_if_rdata = ack_data;
            else if (!g_we) m_dm_rdata = ack_data;
        end

        // Requesters: hold until completion, then maybe issue a fresh request.
        if (if_req && e_ifv) if_req = 1'b0;
        if (!if_req) begin
            if_addr = $urandom;
            if (!quiet && $urandom_range(0, 2) != 0) if_req = 1'b1;
        end
        if (dm_req && e_dmv) dm_req = 1'b0;
        if (!dm_req) begin
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_we    = $urandom_range(0, 1) == 1;
            if (!quiet && $urandom_range(0, 2) != 0) dm_req = 1'b1;
        end

        // Memory: ack exactly at the chosen latency, stray acks only when not busy.
        ram_rdata = $urandom;
        if (busy && cyc == t0 + 1 + lat) begin
            ram_ack  = 1'b1;
            ack_data = ram_rdata;
        end else begin
            ram_ack = !busy && ($urandom_range(0, 3) == 0);
        end

        #1;
        check_eq("ram_req", ram_req, busy);
        if (busy) begin
            check_eq("ram_addr", ram_addr, g_addr);
            check_eq("ram_we", ram_we, g_dm && g_we);
            if (g_dm) check_eq("ram_wdata", ram_wdata, g_wdata);
        end
        check_eq("if_valid", if_valid, e_ifv);
        check_eq("dm_valid", dm_valid, e_dmv);
        check_eq("if_rdata", if_rdata, m_if_rdata);
        check_eq("dm_rdata", dm_rdata, m_dm_rdata);
        check_eq("stall_f", stall_f, if_req && !e_ifv);
        check_eq("stall_m", stall_m, dm_req && !e_dmv);

        // Grant decision at the rising edge that ends an idle cycle.
        if (model_idle() && (if_req || dm_req)) begin
`ifdef ARB_STARVE_EN
            pick_if = if_req && (!dm_req || streak == SMAX);
`else
            pick_if = if_req && !dm_req;
`endif
            active  = 1'b1;
            t0      = cyc;
            lat     = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            g_dm    = !pick_if;
            g_we    = g_dm && dm_we;
            g_addr  = g_dm ? dm_addr : if_addr;
            g_wdata = dm_wdata;
            streak  = (g_dm && if_req) ? streak + 1 : 0;
            if (g_dm) n_dm++;
            else n_if++;
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        bit pending;
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; ram_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; ram_rdata = '0;
        active = 1'b0; t0 = 0; lat = 0; cyc = 0; streak = 0; quiet = 1'b0;
        m_if_rdata = '0; m_dm_rdata = '0; ack_data = '0; n_if = 0; n_dm = 0;
        g_dm = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        repeat (600) step();

        // Drain, then reset in the middle of a load that is waiting for its ack.
        quiet = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (model_idle() && !if_req && !dm_req) break;
            step();
        end
        pending = !model_idle() || if_req || dm_req;
        check_eq("drain_timeout", pending, 0);

        ram_ack = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        @(negedge clk);
        check_eq("mid_busy_ram_req", ram_req, 1);
        check_eq("mid_busy_ram_addr", ram_addr, 32'h40);
        rst = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        check_eq("in_reset_ram_req", ram_req, 0);
        @(negedge clk);
        check_all_zero("after_reset");
        rst = 1'b1; ram_ack = 1'b1; ram_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ram_ack = 1'b0;
            check_eq("late_ack_ram_req", ram_req, 0);
            check_eq("late_ack_if_valid", if_valid, 0);
            check_eq("late_ack_dm_valid", dm_valid, 0);
            check_eq("late_ack_dm_rdata", dm_rdata, 0);
        end

        active = 1'b0; streak = 0; quiet = 1'b0;
        m_if_rdata = '0; m_dm_rdata = '0;
        repeat (400) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared instruction/data memory port of the 5-stage RISC pipeline between the Fetch stage (instruction reads) and the Memory stage (data loads/stores). It owns a small FSM that grants one requester at a time, drives the memory-side request/acknowledge handshake with variable latency, and returns read data with a one-cycle valid pulse. It also produces the stall signals the pipeline uses to freeze Fetch and Memory while their access is pending.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive data grants while fetch waits (used only with ARB_STARVE_EN)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- if_req  in  1  fetch request, level; held until if_valid
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  instruction returned
- if_valid  out  1  one-cycle pulse: fetch access complete
- stall_f  out  1  freeze Fetch
- dm_req  in  1  data request, level; held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data returned
- dm_valid  out  1  one-cycle pulse: data access complete
- stall_m  out  1  freeze Memory stage
- ram_req  out  1  memory request, held until ram_ack
- ram_we  out  1  memory write enable
- ram_addr  out  ADDR_W  memory address
- ram_wdata  out  DATA_W  memory write data
- ram_rdata  in  DATA_W  memory read data, valid with ram_ack
- ram_ack  in  1  one-cycle completion from memory

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE: sample if_req/dm_req. None -> stay. Only one -> grant it. Both -> grant DM (older instruction), subject to starvation rule. On grant, latch address/we/wdata into internal registers; go BUSY_IF or BUSY_DM.
- BUSY_x: ram_req=1, ram_addr/ram_we/ram_wdata from latched registers (ram_we=0 in BUSY_IF). Requester inputs ignored. On ram_ack: capture ram_rdata into if_rdata (BUSY_IF) or dm_rdata (BUSY_DM loads only); go DONE.
- DONE: pulse the matching x_valid for exactly this cycle; requests not sampled; go IDLE.
- Stores: dm_valid pulses on completion; dm_rdata keeps its previous value.
- stall_f = if_req & ~if_valid; stall_m = dm_req & ~dm_valid (combinational from registered valids).
- ram_ack outside BUSY_x is ignored.
- Reset (rst=0): state IDLE; ram_req, ram_we, if_valid, dm_valid = 0; if_rdata, dm_rdata, ram_addr, ram_wdata = 0; starve counter = 0. Reset mid-access abandons it with no valid pulse; a late ram_ack is ignored.

## Timing
- Request seen in IDLE at cycle 0 -> ram_req high from cycle 1.
- Memory acks at cycle 1+L (L >= 0 extra cycles; ack can arrive in the first BUSY cycle) -> x_valid and rdata at cycle 2+L -> IDLE at 3+L.
- Minimum turnaround with zero-wait memory: 3 cycles per access; back-to-back accesses from the same or other requester start at cycle 3+L.
- Requesters update req/addr on the edge ending the DONE cycle; the IDLE cycle samples the new value.

## Configuration
- ARB_STARVE_EN defined: counter (width $clog2(STARVE_MAX+1)) increments on each DM grant made while if_req=1; clears on any IF grant or when an arbitration occurs with if_req=0. When counter == STARVE_MAX and both request, IF is granted instead of DM.
- Not defined: strict DM priority; counter absent; fetch can be starved indefinitely.

## Test plan
- Reset: drive rst=0 for 2 cycles mid BUSY_DM with ram_ack pending -> after reset all outputs 0, state IDLE, subsequent stray ram_ack produces no valid.
- Single fetch, if_addr=0x10, ram_ack 2 cycles after ram_req rises, ram_rdata=0xDEADBEEF -> ram_req high 3 cycles, if_valid one pulse with if_rdata=0xDEADBEEF, stall_f high every cycle until that pulse.
- Simultaneous if_req/dm_req (dm load addr 0x40) with zero-wait memory -> DM granted first, dm_valid at cycle 2; IF ram_req starts cycle 4, if_valid at cycle 5.
- Store dm_we=1, dm_addr=0x80, dm_wdata=0x1234 -> ram_we=1, ram_wdata=0x1234 during BUSY_DM; dm_valid pulses; dm_rdata unchanged.
- ARB_STARVE_EN, STARVE_MAX=4, both requesting continuously -> grant sequence DM,DM,DM,DM,IF,DM…; without macro -> only DM grants.
- ram_ack held low 20 cycles -> ram_req/address stable throughout, no valid, both stalls as required.
